// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle for uart_tx: request/data in, line and status out.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output tx_start, output tx_data, input tx, input busy, input done);
    modport slave  (input tx_start, input tx_data, output tx, output busy, output done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the parity bit (11-bit frame instead of 10).
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    uart_tx_if.slave   bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             tx_q;
    logic             done_q;
    logic             bit_end;
    logic             load;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // The final stop-bit cycle also accepts a request, so held requests chain with no idle gap.
    assign load = bus.tx_start && ((state == IDLE) || ((state == STOP) && bit_end));

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= (state == STOP) && bit_end;
            if (load) begin
                state     <= START;
                cnt       <= '0;
                bit_idx   <= '0;
                shift_reg <= bus.tx_data;
                tx_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_q  <= ^bus.tx_data;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx_q <= 1'b1;
                        cnt  <= '0;
                    end
                    START: begin
                        if (bit_end) begin
                            cnt   <= '0;
                            state <= DATA;
                            tx_q  <= shift_reg[0];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            cnt       <= '0;
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx_q  <= parity_q;
`else
                                state <= STOP;
                                tx_q  <= 1'b1;
`endif
                            end else begin
                                tx_q <= shift_reg[1];
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            cnt   <= '0;
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        tx_q <= 1'b1;
                        if (bit_end) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        tx_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random bytes against a frame-level model.
module tb_uart_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * C;

    logic clk;
    logic n_rst;
    int   checks;
    int   failures;

    uart_tx_if u_if ();

    uart_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic applyStimulus(input logic [7:0] data);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = data;
    endtask

    // Whole serial frame as the line should show it, one entry per bit period.
    task automatic buildFrame(input logic [7:0] data, output bit q[$]);
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
        q.push_back(^data);
`endif
        q.push_back(1'b1);
    endtask

    // Checks every cycle of one frame whose accept edge was the previous posedge.
    task automatic runFrame(input logic [7:0] data, input bit done_at_start, input bit hold,
                            input bit chain, input logic [7:0] next_data,
                            input int poke_t, input logic [7:0] poke_data);
        bit q[$];
        buildFrame(data, q);
        for (int t = 0; t < F; t++) begin
            @(negedge clk);
            checkOutput($sformatf("tx data=%h t=%0d", data, t), u_if.tx, q[t / C]);
            checkOutput($sformatf("busy data=%h t=%0d", data, t), u_if.busy, 1'b1);
            checkOutput($sformatf("done data=%h t=%0d", data, t), u_if.done,
                        (t == 0) && done_at_start);
            u_if.tx_data  = 8'($urandom);
            u_if.tx_start = hold;
            if (t == poke_t) begin
                u_if.tx_start = 1'b1;
                u_if.tx_data  = poke_data;
            end
            if (t == F - 1) begin
                u_if.tx_start = chain;
                if (chain) u_if.tx_data = next_data;
            end
        end
    endtask

    task automatic checkIdleAfter(input string tag);
        @(negedge clk);
        checkOutput({tag, " done pulse"}, u_if.done, 1'b1);
        checkOutput({tag, " busy end"}, u_if.busy, 1'b0);
        checkOutput({tag, " tx end"}, u_if.tx, 1'b1);
        @(negedge clk);
        checkOutput({tag, " done clear"}, u_if.done, 1'b0);
        checkOutput({tag, " busy idle"}, u_if.busy, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        checks        = 0;
        failures      = 0;
        n_rst         = 1'b1;
        u_if.tx_start = 1'b0;
        u_if.tx_data  = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset tx", u_if.tx, 1'b1);
        checkOutput("reset busy", u_if.busy, 1'b0);
        checkOutput("reset done", u_if.done, 1'b0);
        n_rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            u_if.tx_data = 8'($urandom);
            checkOutput($sformatf("idle tx c=%0d", i), u_if.tx, 1'b1);
            checkOutput($sformatf("idle busy c=%0d", i), u_if.busy, 1'b0);
            checkOutput($sformatf("idle done c=%0d", i), u_if.done, 1'b0);
        end

        $display("[TB] single byte A5");
        applyStimulus(8'hA5);
        runFrame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, -1, 8'h00);
        checkIdleAfter("A5");

        $display("[TB] parity bytes 07 and 03");
        applyStimulus(8'h07);
        runFrame(8'h07, 1'b0, 1'b0, 1'b0, 8'h00, -1, 8'h00);
        checkIdleAfter("07");
        applyStimulus(8'h03);
        runFrame(8'h03, 1'b0, 1'b0, 1'b0, 8'h00, -1, 8'h00);
        checkIdleAfter("03");

        $display("[TB] back-to-back 55 then 0F with start held");
        applyStimulus(8'h55);
        runFrame(8'h55, 1'b0, 1'b1, 1'b1, 8'h0F, -1, 8'h00);
        runFrame(8'h0F, 1'b1, 1'b0, 1'b0, 8'h00, -1, 8'h00);
        checkIdleAfter("0F");

        $display("[TB] request during data bit 3 is ignored");
        applyStimulus(8'h00);
        runFrame(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4 * C + 1, 8'hFF);
        checkIdleAfter("00");

        $display("[TB] reset during data bit 5");
        d = 8'($urandom) & 8'hDF;
        applyStimulus(d);
        @(negedge clk);
        u_if.tx_start = 1'b0;
        repeat (6 * C + 1) @(negedge clk);
        checkOutput("pre-reset tx bit5", u_if.tx, 1'b0);
        checkOutput("pre-reset busy", u_if.busy, 1'b1);
        #2 n_rst = 1'b1;
        #1;
        checkOutput("async reset tx", u_if.tx, 1'b1);
        checkOutput("async reset busy", u_if.busy, 1'b0);
        checkOutput("async reset done", u_if.done, 1'b0);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post-reset tx", u_if.tx, 1'b1);
        checkOutput("post-reset busy", u_if.busy, 1'b0);
        applyStimulus(8'h3C);
        runFrame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, -1, 8'h00);
        checkIdleAfter("3C");

        $display("[TB] random bytes");
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d = 8'($urandom);
            applyStimulus(d);
            runFrame(d, 1'b0, 1'b0, 1'b0, 8'h00, -1, 8'h00);
            checkIdleAfter($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one 8-bit byte per request into an asynchronous frame: start bit, 8 data bits LSB-first, optional even-parity bit, one stop bit. It is the transmit-side counterpart of the team's UART_Rx block and drives a line that UART_Rx samples. Bit timing comes from an internal clock-divide counter, so the same clock domain and baud parameter can be shared with the receiver.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
- CNT_W, default 16: width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset, asynchronous and active-high (asserted when 1 despite the name).
- tx_start  input  1  request to send; sampled only in IDLE.
- tx_data  input  8  byte to send; captured on the accepting edge.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: tx=1, busy=0. If tx_start=1 on a rising edge: latch tx_data into shift register, clear bit counter and timing counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift_reg[0]; after each CLKS_PER_BIT cycles shift right and increment the 3-bit bit index; after bit index 7 completes go to PARITY (macro on) or STOP.
- PARITY: tx = XOR of the latched byte (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with done=1 for exactly that one cycle.
- tx is registered (driven from a flop), never combinational from state decode, to avoid glitches.
- tx_start while busy=1 is ignored; no queueing.
- tx_data changes after acceptance have no effect on the current frame.
- Reset (any time, including mid-frame): state=IDLE, tx=1, busy=0, done=0, counters and shift register cleared; partial frame abandoned.

## Timing
- Reset values: tx=1, busy=0, done=0.
- Accept edge E (IDLE, tx_start=1): from E onward tx=0 and busy=1.
- Start bit spans cycles E..E+CLKS_PER_BIT-1; data bit k spans E+(k+1)*CLKS_PER_BIT onward for CLKS_PER_BIT cycles.
- Frame length F = 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- At edge E+F: state=IDLE, busy=0, done=1 for one cycle, tx=1.
- A tx_start high at edge E+F (the done cycle) is accepted, giving back-to-back frames with no idle gap beyond the stop bit.
- tx_start held continuously high produces back-to-back frames, one per F cycles.
- Timing counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary; bit index wraps 7->0 on leaving DATA.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state compiled in; frame is 11 bits with even parity (parity bit = ^tx_data); matches UART_Rx parity checking.
- Undefined: no PARITY state or parity logic; frame is 10 bits, STOP follows data bit 7 directly.

## Test plan
- Reset: n_rst=1 at t=0 then released -> tx=1, busy=0, done=0; no activity with tx_start=0 for 100 cycles.
- Single byte, CLKS_PER_BIT=4, tx_data=8'hA5, macro off -> tx bits (sampled mid-bit) 0,1,0,1,0,0,1,0,1,1; done pulses once at 40 cycles after accept; busy high exactly 40 cycles.
- Parity, macro on, tx_data=8'h07 -> parity bit 1, frame 0,1,1,1,0,0,0,0,0,1,1 over 44 cycles; tx_data=8'h03 -> parity bit 0.
- Back-to-back: tx_start held high, bytes 8'h55 then 8'h0F -> second start bit begins on the done cycle; no extra idle bit; two done pulses 40 cycles apart.
- Ignored request: pulse tx_start with tx_data=8'hFF during data bit 3 of an 8'h00 frame -> frame still all-zero data; only one done.
- Reset mid-frame: assert n_rst during data bit 5 -> tx=1, busy=0 immediately (asynchronous); after release, new request 8'h3C sends a clean full frame.
